decode_sched: RTL and testbench
===============================

DECODE_SCHED -- requirements
Module: decode_sched

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum GRANT cycles for one owner while another requester is pending; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req  input  10  level request per requester, index 0..9.
REQ-005 Port: flush  input  1  synchronous abort of the current grant.
REQ-006 Port: sel_n  output  10  active-low one-hot select of the owner; all ones when no owner.
REQ-007 Port: code  output  4  binary index of the owner, 0..9.
REQ-008 Port: code_vld  output  1  high exactly when code and sel_n name an owner.
REQ-009 Port: busy  output  1  high in GRANT and RELEASE states.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-011 In IDLE with req nonzero, the block SHALL select the winner and enter GRANT on the next edge; the winner is the first set req bit after the round-robin pointer, searching upward with wrap 9->0.
REQ-012 In IDLE with req zero, the block SHALL stay in IDLE.
REQ-013 On entry to GRANT, the block SHALL drive sel_n[w]=0, all other sel_n bits=1, code=w, code_vld=1, and set the pointer to w; all outputs are registered, so latency is 1 cycle from the sampled req.
REQ-014 In GRANT, a hold counter SHALL start at 0 and increment each cycle, saturating at MAX_HOLD-1.
REQ-015 GRANT SHALL exit to RELEASE on the next edge when any of these holds: req[owner]=0; flush=1; the counter equals MAX_HOLD-1 and another req bit is set.
REQ-016 When the counter saturates and no other req bit is set, GRANT SHALL hold indefinitely.
REQ-017 RELEASE SHALL last exactly one cycle with sel_n=10'h3FF and code_vld=0, giving break-before-make; it then enters IDLE.
REQ-018 code SHALL retain its last value whenever code_vld=0.
REQ-019 req changes during RELEASE SHALL be ignored, and arbitration SHALL resume in IDLE; the previous owner therefore has lowest priority.
REQ-020 flush in IDLE or RELEASE SHALL have no effect.
REQ-021 Simultaneous exit conditions SHALL produce a single RELEASE.
REQ-022 At most one sel_n bit SHALL be low in any cycle.

Reset
REQ-023 While rst_n=0, the block SHALL immediately set state=IDLE, sel_n=10'h3FF, code=0, code_vld=0, busy=0, hold counter=0, and pointer=9, so the first search starts at index 0.
REQ-024 Reset asserted mid-GRANT SHALL deassert sel_n without a RELEASE cycle; after release, the first edge with rst_n=1 evaluates IDLE.

Configuration
REQ-025 Macro DECODE_SCHED_PRIO0_EN: when defined, in IDLE, req[0]=1 SHALL always win regardless of the pointer, and in GRANT, req[0]=1 with owner!=0 SHALL force RELEASE on the next edge.
REQ-026 Without DECODE_SCHED_PRIO0_EN, requester 0 SHALL be an ordinary round-robin participant, and no preemption other than REQ-015 SHALL occur.

Verification
REQ-027 Reset, then req=10'h001 at edge N -> sel_n=10'h3FE, code=0, code_vld=1 after edge N+1.
REQ-028 req=10'h003 held, MAX_HOLD=8 -> owner 0 for 8 cycles, 1 RELEASE cycle, 1 IDLE cycle, then owner 1 with sel_n=10'h3FD.
REQ-029 Owner 9 drops req while req[0]=1 -> RELEASE, IDLE, then code=0, confirming wrap 9->0.
REQ-030 Only req[5] held for 40 cycles -> sel_n[5]=0 throughout, with no RELEASE.
REQ-031 flush=1 for 1 cycle in GRANT -> sel_n=10'h3FF on the next cycle; rst_n pulsed low mid-GRANT -> sel_n=10'h3FF immediately.
REQ-032 With DECODE_SCHED_PRIO0_EN, owner 4 active and req[0] rising -> RELEASE next edge, then code=0; without the macro, owner 4 is kept until its hold limit.

Source files
------------

// File: rtl/decode_sched.sv
// decode_sched: 10-way round-robin arbiter with registered active-low one-hot select, binary code and break-before-make release.
// Optional feature: define DECODE_SCHED_PRIO0_EN to give requester 0 absolute priority and preemption rights.
module decode_sched #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req,
    input  logic       flush,
    output logic [9:0] sel_n,
    output logic [3:0] code,
    output logic       code_vld,
    output logic       busy
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] ptr, ptr_nx;
    logic [3:0] hold, hold_nx;
    logic [3:0] code_nx;
    logic [9:0] sel_n_nx;
    logic       code_vld_nx;
    logic       busy_nx;

    logic [3:0] winner;
    logic       found;
    logic [4:0] idx;
    logic [9:0] owner_oh;
    logic       others;
    logic       exit_grant;

    // Round-robin search starts one past the last owner, so the previous owner is tried last.
    always_comb begin
        winner = 4'd0;
        found  = 1'b0;
        idx    = 5'd0;
        for (int i = 1; i <= 10; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'd10) idx = idx - 5'd10;
            if (!found && req[idx[3:0]]) begin
                winner = idx[3:0];
                found  = 1'b1;
            end
        end
`ifdef DECODE_SCHED_PRIO0_EN
        if (req[0]) winner = 4'd0;
`endif
    end

    always_comb begin
        owner_oh   = 10'd1 << code;
        others     = |(req & ~owner_oh);
        exit_grant = !req[code] || flush || ((hold == HOLD_LAST) && others);
`ifdef DECODE_SCHED_PRIO0_EN
        if (req[0] && (code != 4'd0)) exit_grant = 1'b1;
`endif
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        hold_nx     = hold;
        code_nx     = code;
        sel_n_nx    = sel_n;
        code_vld_nx = code_vld;
        busy_nx     = busy;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx    = GRANT;
                    ptr_nx      = winner;
                    hold_nx     = 4'd0;
                    code_nx     = winner;
                    sel_n_nx    = ~(10'd1 << winner);
                    code_vld_nx = 1'b1;
                    busy_nx     = 1'b1;
                end
            end
            GRANT: begin
                if (exit_grant) begin
                    state_nx    = RELEASE;
                    hold_nx     = 4'd0;
                    sel_n_nx    = 10'h3FF;
                    code_vld_nx = 1'b0;
                end else if (hold != HOLD_LAST) begin
                    hold_nx = hold + 4'd1;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx    = IDLE;
                sel_n_nx    = 10'h3FF;
                code_vld_nx = 1'b0;
                busy_nx     = 1'b0;
            end
        endcase
    end

    // Pointer resets to 9 so the very first search begins at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 4'd9;
            hold     <= 4'd0;
            code     <= 4'd0;
            sel_n    <= 10'h3FF;
            code_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold     <= hold_nx;
            code     <= code_nx;
            sel_n    <= sel_n_nx;
            code_vld <= code_vld_nx;
            busy     <= busy_nx;
        end
    end

endmodule

// File: tb/tb_decode_sched.sv
// tb_decode_sched: scoreboard bench for decode_sched; a request/ownership model predicts every output cycle.
// Honours DECODE_SCHED_PRIO0_EN the same way the design does.
module tb_decode_sched;

    localparam int MAX_HOLD = 8;
`ifdef DECODE_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] req;
    logic       flush;
    logic [9:0] sel_n;
    logic [3:0] code;
    logic       code_vld;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    logic [15:0] exp_q[$];

    // Model state: current owner (-1 = none), last winner, cycles owned, release flag, last code.
    int m_owner;
    int m_last;
    int m_held;
    int m_code;
    bit m_rel;

    decode_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .flush    (flush),
        .sel_n    (sel_n),
        .code     (code),
        .code_vld (code_vld),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_owner = -1;
        m_last  = 9;
        m_held  = 0;
        m_code  = 0;
        m_rel   = 1'b0;
    endtask

    function automatic logic [15:0] model_out();
        logic [9:0] s;
        s = 10'h3FF;
        if (m_owner >= 0) s = ~(10'd1 << m_owner);
        return {s, 4'(m_code), (m_owner >= 0), ((m_owner >= 0) || m_rel)};
    endfunction

    task automatic model_step(input logic [9:0] r, input logic f);
        int  w;
        bit  others;
        if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_owner < 0) begin
            if (r != 10'd0) begin
                w = -1;
                if (PRIO0 && r[0]) w = 0;
                else
                    for (int k = 1; k <= 10; k++)
                        if (w < 0 && r[4'((m_last + k) % 10)]) w = (m_last + k) % 10;
                m_owner = w;
                m_last  = w;
                m_code  = w;
                m_held  = 1;
            end
        end else begin
            others = (r & ~(10'd1 << m_owner)) != 10'd0;
            if (!r[4'(m_owner)] || f || (m_held >= MAX_HOLD && others) ||
                (PRIO0 && r[0] && m_owner != 0)) begin
                m_owner = -1;
                m_rel   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual sel_n=%h code=%0d vld=%b busy=%b required sel_n=%h code=%0d vld=%b busy=%b",
                     name, act[15:6], act[5:2], act[1], act[0], want[15:6], want[5:2], want[1], want[0]);
        end
    endtask

    task automatic step(input logic [9:0] r, input logic f);
        req   = r;
        flush = f;
        model_step(r, f);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        model_reset();
        exp_q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a result, compare it with the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty cycle=%0d actual sel_n=%h required a queued prediction", cyc, sel_n);
                end else begin
                    check($sformatf("cycle%0d", cyc), {sel_n, code, code_vld, busy}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [9:0] r;
        int         k;
        req   = 10'd0;
        flush = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_state", {sel_n, code, code_vld, busy}, model_out());
        @(posedge clk);
        #2;
        release_reset();

        // Two contenders from reset: owner 0 up to the hold limit, then owner 1.
        repeat (25) step(10'h003, 1'b0);
        repeat (3)  step(10'h000, 1'b0);

        // Owner 9 drops while requester 0 waits: wrap 9 -> 0.
        repeat (3)  step(10'h200, 1'b0);
        repeat (5)  step(10'h001, 1'b0);
        repeat (2)  step(10'h000, 1'b0);

        // Lone requester keeps the grant indefinitely.
        repeat (40) step(10'h020, 1'b0);

        // Flush aborts the grant for one release cycle, then the same requester returns.
        step(10'h020, 1'b1);
        repeat (4)  step(10'h020, 1'b0);
        step(10'h000, 1'b1);
        repeat (2)  step(10'h000, 1'b0);

        // Owner 4 with requester 0 rising.
        repeat (3)  step(10'h010, 1'b0);
        repeat (14) step(10'h011, 1'b0);
        repeat (3)  step(10'h000, 1'b0);

        // Asynchronous reset in the middle of a grant.
        repeat (3)  step(10'h080, 1'b0);
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_mid_grant", {sel_n, code, code_vld, busy}, model_out());
        @(posedge clk);
        @(posedge clk);
        #2;
        release_reset();
        repeat (6)  step(10'h080, 1'b0);

        // Randomized request toggling with occasional flush.
        r = 10'd0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 9));
                r[k] = ~r[k];
            end
            step(r, ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
